// File: rtl/int_ctrl.sv
// Interrupt controller: per-source edge/level capture, masking, fixed
// lowest-index priority and a request/ack/eoi handshake with the CPU.
module int_ctrl #(
  parameter int unsigned NSRC      = 6,
  parameter logic [29:0] BASE_ADDR = 30'h1FCC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic [29:0]     addr,
  input  logic            we,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  input  logic            int_ack,
  input  logic            int_eoi,
  output logic            irq_req,
  output logic [2:0]      irq_id,
  output logic [NSRC-1:0] HWInt
);

  localparam int unsigned AW = 30;
  localparam int unsigned IW = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e          state_q;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] mask_q;
  logic [NSRC-1:0] mode_q;
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] hwint_q;
  logic            irq_req_q;
  logic [IW-1:0]   irq_id_q;

  logic [AW-1:0]   offset_c;
  logic            in_range_c;
  logic            wr_pend_c, wr_mask_c, wr_mode_c;
  logic [NSRC-1:0] eligible_c;
  logic [IW-1:0]   winner_c;
  logic [NSRC-1:0] clr_c;
  logic [NSRC-1:0] rise_c;
  logic            unused_wdata_c;

  // Address decode: word offset relative to the block base
  assign offset_c   = addr - BASE_ADDR;
  assign in_range_c = (offset_c < AW'(4));
  assign wr_pend_c  = we && in_range_c && (offset_c[1:0] == 2'd0);
  assign wr_mask_c  = we && in_range_c && (offset_c[1:0] == 2'd1);
  assign wr_mode_c  = we && in_range_c && (offset_c[1:0] == 2'd2);
  assign unused_wdata_c = ^wdata[31:NSRC];

  assign eligible_c = pend_q & mask_q;

  // Fixed priority: lowest eligible index wins
  always_comb begin
    winner_c = '0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (eligible_c[i]) winner_c = IW'(i);
    end
  end

  // Pending next-state: edge bits accumulate rises (set beats clear), level bits follow src
  always_comb begin
    rise_c = src & ~src_q;
    clr_c  = '0;
    if (wr_pend_c) clr_c = wdata[NSRC-1:0];
    if ((state_q == REQ) && int_ack) clr_c = clr_c | (NSRC'(1) << irq_id_q);
    pend_d = (mode_q & ((pend_q & ~clr_c) | rise_c)) | (~mode_q & src);
  end

  // Combinational register read-back; zero outside the window
  always_comb begin
    rdata = '0;
    if (in_range_c) begin
      case (offset_c[1:0])
        2'd0:    rdata = 32'(pend_q);
        2'd1:    rdata = 32'(mask_q);
        2'd2:    rdata = 32'(mode_q);
        default: rdata = {27'd0, state_q, irq_id_q};
      endcase
    end
  end

  // Source sampling, pending/mask/mode registers and HWInt
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_q   <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      mode_q  <= '0;
      hwint_q <= '0;
    end else begin
      src_q   <= src;
      pend_q  <= pend_d;
      hwint_q <= eligible_c;
      if (wr_mask_c) mask_q <= wdata[NSRC-1:0];
      if (wr_mode_c) mode_q <= wdata[NSRC-1:0];
    end
  end

  // Request/ack/eoi handshake; one interrupt in service at a time
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      irq_req_q <= 1'b0;
      irq_id_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|eligible_c) begin
            state_q   <= REQ;
            irq_req_q <= 1'b1;
            irq_id_q  <= winner_c;
          end
        end
        REQ: begin
          if (int_ack) begin
            state_q   <= SERVICE;
            irq_req_q <= 1'b0;
          end else if (!(|eligible_c)) begin
            state_q   <= IDLE;
            irq_req_q <= 1'b0;
          end else begin
            irq_id_q  <= winner_c;
          end
        end
        SERVICE: begin
          irq_req_q <= 1'b0;
          if (int_eoi) state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          irq_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign irq_req = irq_req_q;
  assign irq_id  = irq_id_q;
  assign HWInt   = hwint_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed vector table, async-reset sequence and
// randomized traffic against a behavioural model.
module tb_int_ctrl;

  localparam int          NSRC = 6;
  localparam logic [29:0] BASE = 30'h1FCC;
  localparam int          FULL = (1 << NSRC) - 1;

  logic            clk;
  logic            reset;
  logic [NSRC-1:0] src;
  logic [29:0]     addr;
  logic            we;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic            int_ack;
  logic            int_eoi;
  logic            irq_req;
  logic [2:0]      irq_id;
  logic [NSRC-1:0] HWInt;

  int errors = 0;
  int checks = 0;

  int_ctrl #(.NSRC(NSRC), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .src(src), .addr(addr), .we(we), .wdata(wdata),
    .rdata(rdata), .int_ack(int_ack), .int_eoi(int_eoi), .irq_req(irq_req),
    .irq_id(irq_id), .HWInt(HWInt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state: integers, state as 0 idle / 1 requesting / 2 in service
  int m_pend, m_mask, m_mode, m_srcq, m_state, m_req, m_id, m_hw;

  typedef struct {
    logic [5:0]  s;
    logic        w;
    int          off;
    logic [31:0] wd;
    logic        a;
    logic        e;
    logic        req;
    logic [2:0]  id;
    logic [31:0] rd;
    logic [5:0]  hw;
  } vec_t;

  vec_t tbl[35];

  function automatic logic [29:0] addr_of(input int off);
    case (off)
      4:       return BASE + 30'd4;
      5:       return BASE - 30'd1;
      default: return BASE + 30'(off);
    endcase
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs at the falling edge and return just after the rising edge
  task automatic step(input logic [NSRC-1:0] s, input logic w, input int off,
                      input logic [31:0] wd, input logic a, input logic e);
    @(negedge clk);
    src = s; we = w; addr = addr_of(off); wdata = wd; int_ack = a; int_eoi = e;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pend = 0; m_mask = 0; m_mode = 0; m_srcq = 0;
    m_state = 0; m_req = 0; m_id = 0; m_hw = 0;
  endtask

  // One clock edge of the model, using the inputs currently applied
  task automatic model_edge(input int off);
    int elig, win, clr, rise, s, wd;
    bit acked;
    s = int'(src); wd = int'(wdata) & FULL;
    elig = m_pend & m_mask;
    win = -1;
    for (int i = 0; i < NSRC; i++) if (win < 0 && ((elig >> i) & 1) == 1) win = i;
    acked = 0;
    case (m_state)
      0: if (elig != 0) begin m_state = 1; m_req = 1; m_id = win; end
      1: begin
        if (int_ack) begin m_state = 2; m_req = 0; acked = 1; end
        else if (elig == 0) begin m_state = 0; m_req = 0; end
        else m_id = win;
      end
      default: begin m_req = 0; if (int_eoi) m_state = 0; end
    endcase
    clr = 0;
    if (we && off == 0) clr = wd;
    if (acked) clr = clr | (1 << m_id);
    rise = s & ~m_srcq;
    m_pend = (((m_pend & ~clr) | rise) & m_mode) | (s & ~m_mode & FULL);
    m_hw = elig;
    if (we && off == 1) m_mask = wd;
    if (we && off == 2) m_mode = wd;
    m_srcq = s;
  endtask

  function automatic int model_read(input int off);
    case (off)
      0: return m_pend;
      1: return m_mask;
      2: return m_mode;
      3: return m_state * 8 + m_id;
      default: return 0;
    endcase
  endfunction

  initial begin
    // inputs src, we, off, wdata, ack, eoi | expected req, id, rdata, HWInt
    tbl[0]  = '{6'h00, 0, 0, 32'h0,         0, 0, 0, 3'd0, 32'h00, 6'h00};
    tbl[1]  = '{6'h00, 0, 1, 32'h0,         0, 0, 0, 3'd0, 32'h00, 6'h00};
    tbl[2]  = '{6'h00, 0, 2, 32'h0,         0, 0, 0, 3'd0, 32'h00, 6'h00};
    tbl[3]  = '{6'h00, 0, 3, 32'h0,         0, 0, 0, 3'd0, 32'h00, 6'h00};
    tbl[4]  = '{6'h00, 1, 1, 32'h3F,        0, 0, 0, 3'd0, 32'h3F, 6'h00};
    tbl[5]  = '{6'h00, 1, 2, 32'hFFFF_FFC1, 0, 0, 0, 3'd0, 32'h01, 6'h00};
    tbl[6]  = '{6'h00, 1, 3, 32'hFFFF_FFFF, 0, 0, 0, 3'd0, 32'h00, 6'h00};
    tbl[7]  = '{6'h01, 0, 0, 32'h0,         0, 0, 0, 3'd0, 32'h01, 6'h00};
    tbl[8]  = '{6'h00, 0, 0, 32'h0,         0, 0, 1, 3'd0, 32'h01, 6'h01};
    tbl[9]  = '{6'h00, 0, 0, 32'h0,         1, 0, 0, 3'd0, 32'h00, 6'h01};
    tbl[10] = '{6'h00, 0, 3, 32'h0,         0, 0, 0, 3'd0, 32'h10, 6'h00};
    tbl[11] = '{6'h00, 0, 3, 32'h0,         0, 1, 0, 3'd0, 32'h00, 6'h00};
    tbl[12] = '{6'h00, 0, 3, 32'h0,         0, 1, 0, 3'd0, 32'h00, 6'h00};
    tbl[13] = '{6'h01, 1, 0, 32'h01,        0, 0, 0, 3'd0, 32'h01, 6'h00};
    tbl[14] = '{6'h00, 0, 3, 32'h0,         0, 0, 1, 3'd0, 32'h08, 6'h01};
    tbl[15] = '{6'h00, 0, 3, 32'h0,         1, 0, 0, 3'd0, 32'h10, 6'h01};
    tbl[16] = '{6'h00, 0, 3, 32'h0,         1, 0, 0, 3'd0, 32'h10, 6'h00};
    tbl[17] = '{6'h00, 0, 3, 32'h0,         0, 1, 0, 3'd0, 32'h00, 6'h00};
    tbl[18] = '{6'h00, 1, 2, 32'h03,        0, 0, 0, 3'd0, 32'h03, 6'h00};
    tbl[19] = '{6'h01, 0, 0, 32'h0,         0, 0, 0, 3'd0, 32'h01, 6'h00};
    tbl[20] = '{6'h00, 0, 0, 32'h0,         0, 0, 1, 3'd0, 32'h01, 6'h01};
    tbl[21] = '{6'h00, 0, 0, 32'h0,         1, 0, 0, 3'd0, 32'h00, 6'h01};
    tbl[22] = '{6'h02, 0, 0, 32'h0,         0, 0, 0, 3'd0, 32'h02, 6'h00};
    tbl[23] = '{6'h00, 0, 3, 32'h0,         0, 0, 0, 3'd0, 32'h10, 6'h02};
    tbl[24] = '{6'h00, 0, 3, 32'h0,         0, 1, 0, 3'd0, 32'h00, 6'h02};
    tbl[25] = '{6'h00, 0, 3, 32'h0,         0, 0, 1, 3'd1, 32'h09, 6'h02};
    tbl[26] = '{6'h00, 0, 0, 32'h0,         1, 0, 0, 3'd1, 32'h00, 6'h02};
    tbl[27] = '{6'h00, 0, 4, 32'h0,         0, 1, 0, 3'd1, 32'h00, 6'h00};
    tbl[28] = '{6'h00, 1, 2, 32'h01,        0, 0, 0, 3'd1, 32'h01, 6'h00};
    tbl[29] = '{6'h05, 0, 0, 32'h0,         0, 0, 0, 3'd1, 32'h05, 6'h00};
    tbl[30] = '{6'h04, 0, 0, 32'h0,         0, 0, 1, 3'd0, 32'h05, 6'h05};
    tbl[31] = '{6'h04, 1, 1, 32'h3E,        0, 0, 1, 3'd0, 32'h3E, 6'h05};
    tbl[32] = '{6'h04, 0, 0, 32'h0,         0, 0, 1, 3'd2, 32'h05, 6'h04};
    tbl[33] = '{6'h00, 0, 0, 32'h0,         0, 0, 1, 3'd2, 32'h01, 6'h04};
    tbl[34] = '{6'h00, 0, 3, 32'h0,         0, 0, 0, 3'd2, 32'h02, 6'h00};

    reset = 1'b0; src = '0; we = 1'b0; addr = BASE; wdata = '0;
    int_ack = 1'b0; int_eoi = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_irq_req", 32'(irq_req), 0);
    check("reset_hwint", 32'(HWInt), 0);
    reset = 1'b1;

    // Directed vector table
    for (int i = 0; i < 35; i++) begin
      step(tbl[i].s, tbl[i].w, tbl[i].off, tbl[i].wd, tbl[i].a, tbl[i].e);
      check($sformatf("vec%0d_irq_req", i), 32'(irq_req), 32'(tbl[i].req));
      check($sformatf("vec%0d_irq_id", i), 32'(irq_id), 32'(tbl[i].id));
      check($sformatf("vec%0d_rdata", i), rdata, tbl[i].rd);
      check($sformatf("vec%0d_hwint", i), 32'(HWInt), 32'(tbl[i].hw));
    end

    // Async reset while requesting: everything drops before the next edge
    step(6'h02, 0, 0, 32'h0, 0, 0);
    step(6'h02, 0, 0, 32'h0, 0, 0);
    check("pre_reset_irq_req", 32'(irq_req), 1);
    check("pre_reset_irq_id", 32'(irq_id), 1);
    check("pre_reset_hwint", 32'(HWInt), 32'h02);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_irq_req", 32'(irq_req), 0);
    check("async_reset_irq_id", 32'(irq_id), 0);
    check("async_reset_hwint", 32'(HWInt), 0);
    for (int off = 0; off < 4; off++) begin
      addr = addr_of(off);
      #1;
      check($sformatf("async_reset_rdata%0d", off), rdata, 0);
    end
    @(negedge clk);
    reset = 1'b1;
    step(6'h01, 0, 0, 32'h0, 0, 0);
    check("post_reset_first_sample", rdata, 32'h01);
    check("post_reset_irq_req", 32'(irq_req), 0);

    // Randomized traffic against the model
    @(negedge clk);
    reset = 1'b0; src = '0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int n = 0; n < 2000; n++) begin
      logic [NSRC-1:0] s;
      logic w, a, e;
      int off;
      logic [31:0] wd;
      s   = NSRC'($urandom & $urandom);
      w   = ($urandom_range(0, 5) == 0);
      off = int'($urandom_range(0, 5));
      wd  = $urandom;
      a   = ($urandom_range(0, 3) == 0);
      e   = ($urandom_range(0, 3) == 0);
      step(s, w, off, wd, a, e);
      model_edge(off);
      check("rand_irq_req", 32'(irq_req), 32'(m_req));
      check("rand_irq_id", 32'(irq_id), 32'(m_id));
      check("rand_hwint", 32'(HWInt), 32'(m_hw));
      check("rand_rdata", rdata, 32'(model_read(off)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
